dt_integrator: RTL and testbench
================================

Name: dt_integrator

Overview:
- Inverse of the temperature-derivative estimator: consumes a stream of Q0.7 dT samples and integrates them back into a reconstructed temperature trajectory.
- Used by the controller to predict or track temperature between sparse sensor readings.
- Sits downstream of the derivative estimator and is re-seeded from the measured temperature on init.
- Two-stage pipeline (scale, then accumulate) with a saturating Q8.7 accumulator and a 2-state control FSM.

Parameters:
- K_MAX, 7, largest shift applied to dT (k_dt values above this are treated as K_MAX).
- FRAC, 7, number of fraction bits in dT and in the accumulator.
- ACC_W, 16, accumulator width (signed, Q8.7).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- init  in  1  seed pulse; loads T_seed and flushes the pipeline.
- T_seed  in  8  signed Q7.0 seed temperature.
- dT_in  in  8  signed Q0.7 derivative sample.
- dt_valid  in  1  dT_in is valid this cycle.
- k_dt  in  8  unsigned left-shift applied to dT_in; effective value is min(k_dt, K_MAX).
- t_min  in  8  signed Q7.0 lower clamp.
- t_max  in  8  signed Q7.0 upper clamp.
- T_out  out  8  signed Q7.0 reconstructed temperature (floor of the accumulator).
- t_valid  out  1  one-cycle pulse when T_out updates from a dT sample.
- sat_hi  out  1  last update was clamped to t_max.
- sat_lo  out  1  last update was clamped to t_min.
- cfg_err  out  1  t_min > t_max; no updates are taken while high.
- running  out  1  FSM is in S_RUN.

Behaviour:
- Reset (asynchronous, active-high), all registers cleared:
  - acc=0, inc_r=0, v1=0.
  - T_out=0, t_valid=0, sat_hi=0, sat_lo=0, running=0.
  - FSM in S_IDLE.
  - Reset asserted mid-pipeline discards any in-flight sample.
- FSM:
  - S_IDLE: dt_valid is ignored, no stage-1 capture. init moves to S_RUN.
  - S_RUN: init stays in S_RUN and re-seeds. There is no other exit except rst.
- init (any state), on the same edge:
  - acc <= clamp(sxt(T_seed)<<<7).
  - T_out <= clamp(T_seed).
  - v1 <= 0; any stage-1 sample is dropped.
  - sat flags cleared.
  - t_valid stays 0 (no pulse for a seed).
  - init together with dt_valid: init wins and the sample is dropped.
- Stage 1 (capture), S_RUN, dt_valid=1, init=0, cfg_err=0:
  - inc_r <= sxt16(dT_in) <<< k_eff.
  - v1 <= 1; otherwise v1 <= 0.
  - Maximum magnitude is 128<<7 = 16384, so there is no overflow in 16 bits.
- Stage 2 (accumulate), when v1=1 and init=0:
  - sum17 = sxt(acc) + sxt(inc_r).
  - lo = t_min<<<7, hi = t_max<<<7.
  - sum17 > hi: acc <= hi, sat_hi=1, sat_lo=0.
  - sum17 < lo: acc <= lo, sat_lo=1, sat_hi=0.
  - Otherwise: acc <= sum17, both flags 0.
  - T_out <= next_acc[14:7] (arithmetic floor).
  - t_valid <= 1; otherwise t_valid <= 0.
- Latency: dt_valid sampled at edge N gives T_out and t_valid at edge N+2.
  - Throughput is one sample per cycle; back-to-back dt_valid is supported.
- cfg_err:
  - Combinational (t_min > t_max), also driven as an output.
  - While high: stage-1 capture is blocked. A stage-2 sample already in flight completes, but acc holds its value (no clamp applied).
  - init while cfg_err is high still loads T_seed unclamped.
- Clamp bounds are read live each cycle.
  - Changing t_min or t_max does not retroactively clamp acc; the new bounds apply on the next update.

Decomposition:
- Package dt_pkg holds:
  - Q-format constants: FRAC=7, K_MAX=7, ACC_W=16.
  - typedef q8_7_t (signed 16) and q0_7_t (signed 8).
  - enum dti_state_t {S_IDLE, S_RUN}.
  - Helper functions sxt16 and shl_sat_k.
- One sub-module: q_clamp, a combinational 17-bit signed clamp against lo/hi that returns the clamped value plus hi/lo flags. It is shared by the init path and stage 2.

Test Plan:
- Reset, then 5 dt_valid pulses with dT_in=64 and no init -> T_out=0, t_valid never asserts, running=0.
- init with T_seed=10, then dT_in=64, k_dt=1 (inc=128) -> exactly 2 cycles after dt_valid: T_out=11, one-cycle t_valid pulse, sat flags 0.
- Seed 10, k_dt=0, dT_in=64 back-to-back twice -> T_out=10 then 11 on consecutive cycles (10.5 floors to 10).
- Seed 10, dT_in=-128, k_dt=3 (inc=-1024) -> T_out=2.
  - k_dt=200 is treated as 7: seed 10, dT_in=-1 -> T_out=9.
- t_max=20, seed 18, dT_in=127, k_dt=7 -> T_out=20, sat_hi=1.
  - Next sample dT_in=-128, k_dt=7 with t_min=-5 -> T_out=-5, sat_lo=1, sat_hi=0.
- Edge cases, each checked:
  - init on the same cycle as dt_valid -> seed loaded, no t_valid.
  - init one cycle after dt_valid -> stage-1 sample dropped, no t_valid.
  - rst mid-pipeline -> all outputs 0.
  - t_min=30, t_max=20 -> cfg_err=1 and dT samples produce no t_valid.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared fixed-point types, constants and helpers for the dT integrator.
// Latency: none (package only).
// Backpressure: none (package only).
package dt_pkg;

    // Fraction bits in both the dT samples and the accumulator.
    localparam int FRAC  = 7;
    // Largest left shift applied to an incoming dT sample.
    localparam int K_MAX = 7;
    // Accumulator width, signed Q8.7.
    localparam int ACC_W = 16;

    typedef logic signed [ACC_W-1:0] q8_7_t;
    typedef logic signed [7:0]       q0_7_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } dti_state_t;

    // Sign-extend an 8-bit Q0.7 sample to accumulator width.
    function automatic q8_7_t sxt16(input q0_7_t v);
        return {{(ACC_W-8){v[7]}}, v};
    endfunction

    // Effective shift amount: k_dt saturated to K_MAX.
    function automatic logic [2:0] shl_sat_k(input logic [7:0] k);
        if (k > 8'(K_MAX)) begin
            return 3'(K_MAX);
        end
        return k[2:0];
    endfunction

endpackage

// File: rtl/q_clamp.sv
// Combinational signed clamp of a 17-bit value to [i_lo, i_hi] with hit flags.
// Latency: zero (pure combinational).
// Backpressure: none; output follows inputs every cycle.
module q_clamp (
    input  logic signed [16:0] i_val,
    input  logic signed [16:0] i_lo,
    input  logic signed [16:0] i_hi,
    output logic signed [15:0] o_val,
    output logic               o_hi,
    output logic               o_lo
);

    // Bounds come from 8-bit Q7.0 limits, so any in-range result fits 16 bits.
    always_comb begin
        o_val = i_val[15:0];
        o_hi  = 1'b0;
        o_lo  = 1'b0;
        if (i_val > i_hi) begin
            o_val = i_hi[15:0];
            o_hi  = 1'b1;
        end else if (i_val < i_lo) begin
            o_val = i_lo[15:0];
            o_lo  = 1'b1;
        end
    end

endmodule

// File: rtl/dt_integrator.sv
// Integrates Q0.7 dT samples into a saturating Q8.7 temperature, re-seeded by init.
// Latency: two register stages (scale, accumulate); a sample shows on T_out two cycles after dt_valid.
// Backpressure: none; one sample per cycle accepted, samples blocked while idle or cfg_err is high.
module dt_integrator
    import dt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic [7:0] T_seed,
    input  logic [7:0] dT_in,
    input  logic       dt_valid,
    input  logic [7:0] k_dt,
    input  logic [7:0] t_min,
    input  logic [7:0] t_max,
    output logic [7:0] T_out,
    output logic       t_valid,
    output logic       sat_hi,
    output logic       sat_lo,
    output logic       cfg_err,
    output logic       running
);

    dti_state_t r_state;
    q8_7_t      r_acc;
    q8_7_t      r_inc;
    logic       r_v1;
    logic [7:0] r_t_out;
    logic       r_t_valid;
    logic       r_sat_hi;
    logic       r_sat_lo;

    logic              w_cfg_err;
    logic              w_capture;
    logic [2:0]        w_k_eff;
    logic signed [16:0] w_seed17;
    logic signed [16:0] w_sum17;
    logic signed [16:0] w_lo17;
    logic signed [16:0] w_hi17;
    logic signed [16:0] w_clamp_in;
    logic signed [15:0] w_clamp_val;
    logic              w_clamp_hi;
    logic              w_clamp_lo;
    q8_7_t             w_seed_acc;

    assign w_cfg_err = $signed(t_min) > $signed(t_max);
    assign w_k_eff   = shl_sat_k(k_dt);
    assign w_capture = (r_state == S_RUN) && dt_valid && !init && !w_cfg_err;

    // Q7.0 values promoted to Q8.7 in 17 bits so the clamp sees no overflow.
    assign w_seed17 = {{2{T_seed[7]}}, T_seed, {FRAC{1'b0}}};
    assign w_lo17   = {{2{t_min[7]}},  t_min,  {FRAC{1'b0}}};
    assign w_hi17   = {{2{t_max[7]}},  t_max,  {FRAC{1'b0}}};
    assign w_sum17  = {r_acc[ACC_W-1], r_acc} + {r_inc[ACC_W-1], r_inc};

    // One clamp serves both paths; init has priority over stage 2 anyway.
    assign w_clamp_in = init ? w_seed17 : w_sum17;

    q_clamp u_clamp (
        .i_val (w_clamp_in),
        .i_lo  (w_lo17),
        .i_hi  (w_hi17),
        .o_val (w_clamp_val),
        .o_hi  (w_clamp_hi),
        .o_lo  (w_clamp_lo)
    );

    // With inverted bounds the clamp is meaningless, so the seed goes in raw.
    assign w_seed_acc = w_cfg_err ? w_seed17[ACC_W-1:0] : w_clamp_val;

    // Control FSM: init is the only way out of idle; only reset returns there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (init) begin
            r_state <= S_RUN;
        end
    end

    // Stage 1: scale the incoming sample by 2^k_eff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inc <= '0;
            r_v1  <= 1'b0;
        end else begin
            r_v1 <= w_capture;
            if (w_capture) begin
                r_inc <= sxt16(q0_7_t'(dT_in)) <<< w_k_eff;
            end
        end
    end

    // Stage 2: seed or accumulate with saturation, and publish the floor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_t_out   <= '0;
            r_t_valid <= 1'b0;
            r_sat_hi  <= 1'b0;
            r_sat_lo  <= 1'b0;
        end else if (init) begin
            r_acc     <= w_seed_acc;
            r_t_out   <= w_seed_acc[14:7];
            r_t_valid <= 1'b0;
            r_sat_hi  <= 1'b0;
            r_sat_lo  <= 1'b0;
        end else if (r_v1) begin
            r_t_valid <= 1'b1;
            if (w_cfg_err) begin
                // In-flight sample completes but the accumulator is frozen.
                r_t_out <= r_acc[14:7];
            end else begin
                r_acc    <= w_clamp_val;
                r_t_out  <= w_clamp_val[14:7];
                r_sat_hi <= w_clamp_hi;
                r_sat_lo <= w_clamp_lo;
            end
        end else begin
            r_t_valid <= 1'b0;
        end
    end

    assign T_out   = r_t_out;
    assign t_valid = r_t_valid;
    assign sat_hi  = r_sat_hi;
    assign sat_lo  = r_sat_lo;
    assign cfg_err = w_cfg_err;
    assign running = (r_state == S_RUN);

endmodule

// File: tb/tb_dt_integrator.sv
// Self-checking bench for dt_integrator: directed scenarios plus a randomized run
// compared against an integer-arithmetic reference model.
module tb_dt_integrator;

    logic       clk;
    logic       rst;
    logic       init;
    logic [7:0] T_seed;
    logic [7:0] dT_in;
    logic       dt_valid;
    logic [7:0] k_dt;
    logic [7:0] t_min;
    logic [7:0] t_max;
    logic [7:0] T_out;
    logic       t_valid;
    logic       sat_hi;
    logic       sat_lo;
    logic       cfg_err;
    logic       running;

    int checks;
    int failures;

    dt_integrator dut (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .T_seed   (T_seed),
        .dT_in    (dT_in),
        .dt_valid (dt_valid),
        .k_dt     (k_dt),
        .t_min    (t_min),
        .t_max    (t_max),
        .T_out    (T_out),
        .t_valid  (t_valid),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo),
        .cfg_err  (cfg_err),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers (drive only; each test does its own comparisons).
    task automatic seed(input int s);
        @(negedge clk);
        init   = 1'b1;
        T_seed = 8'(s);
        @(negedge clk);
        init   = 1'b0;
    endtask

    task automatic send(input int d, input int k);
        dT_in    = 8'(d);
        k_dt     = 8'(k);
        dt_valid = 1'b1;
        @(negedge clk);
        dt_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (T_out !== 8'd0 || t_valid !== 1'b0 || sat_hi !== 1'b0 || sat_lo !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL reset: T_out=%0d t_valid=%b sat_hi=%b sat_lo=%b running=%b, want all 0",
                     $signed(T_out), t_valid, sat_hi, sat_lo, running);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_ignore();
        int seen;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dT_in = 8'd64; k_dt = 8'd0; dt_valid = 1'b1;
            if (t_valid === 1'b1) seen++;
        end
        @(negedge clk);
        dt_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (t_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || T_out !== 8'd0 || running !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore: t_valid pulses=%0d T_out=%0d running=%b, want 0/0/0",
                     seen, $signed(T_out), running);
        end
    endtask

    task automatic test_single();
        seed(10);
        checks++;
        if (T_out !== 8'd10 || t_valid !== 1'b0 || running !== 1'b1) begin
            failures++;
            $display("FAIL seed10: T_out=%0d t_valid=%b running=%b, want 10/0/1", $signed(T_out), t_valid, running);
        end
        send(64, 1);
        checks++;
        if (t_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early: t_valid=%b one cycle after dt_valid, want 0", t_valid);
        end
        @(negedge clk);
        checks++;
        if (T_out !== 8'd11 || t_valid !== 1'b1 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
            failures++;
            $display("FAIL single: T_out=%0d t_valid=%b sat=%b%b, want 11/1/00", $signed(T_out), t_valid, sat_hi, sat_lo);
        end
        @(negedge clk);
        checks++;
        if (t_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse: t_valid=%b after pulse, want 0", t_valid);
        end
    endtask

    task automatic test_back_to_back();
        seed(10);
        dT_in = 8'd64; k_dt = 8'd0; dt_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dt_valid = 1'b0;
        checks++;
        if (T_out !== 8'd10 || t_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: T_out=%0d t_valid=%b, want 10/1", $signed(T_out), t_valid);
        end
        @(negedge clk);
        checks++;
        if (T_out !== 8'd11 || t_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: T_out=%0d t_valid=%b, want 11/1", $signed(T_out), t_valid);
        end
        @(negedge clk);
        checks++;
        if (t_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: t_valid=%b, want 0", t_valid);
        end
    endtask

    task automatic test_negative();
        seed(10);
        send(-128, 3);
        @(negedge clk);
        checks++;
        if (T_out !== 8'd2 || t_valid !== 1'b1) begin
            failures++;
            $display("FAIL negative: T_out=%0d t_valid=%b, want 2/1", $signed(T_out), t_valid);
        end
        seed(10);
        send(-1, 200);
        @(negedge clk);
        checks++;
        if (T_out !== 8'd9 || t_valid !== 1'b1) begin
            failures++;
            $display("FAIL k_sat: T_out=%0d t_valid=%b, want 9/1", $signed(T_out), t_valid);
        end
    endtask

    task automatic test_saturation();
        t_max = 8'd20;
        seed(18);
        send(127, 7);
        @(negedge clk);
        checks++;
        if (T_out !== 8'd20 || sat_hi !== 1'b1 || sat_lo !== 1'b0) begin
            failures++;
            $display("FAIL sat_hi: T_out=%0d sat_hi=%b sat_lo=%b, want 20/1/0", $signed(T_out), sat_hi, sat_lo);
        end
        t_min = 8'(-5);
        send(-128, 7);
        @(negedge clk);
        checks++;
        if (T_out !== 8'(-5) || sat_lo !== 1'b1 || sat_hi !== 1'b0) begin
            failures++;
            $display("FAIL sat_lo: T_out=%0d sat_hi=%b sat_lo=%b, want -5/0/1", $signed(T_out), sat_hi, sat_lo);
        end
        t_min = 8'h80;
        t_max = 8'h7f;
        seed(0);
        checks++;
        if (sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
            failures++;
            $display("FAIL sat_clear: sat_hi=%b sat_lo=%b after init, want 0/0", sat_hi, sat_lo);
        end
    endtask

    task automatic test_init_same_cycle();
        int seen;
        seen = 0;
        seed(10);
        dT_in = 8'd64; k_dt = 8'd1; dt_valid = 1'b1;
        init = 1'b1; T_seed = 8'd40;
        @(negedge clk);
        init = 1'b0; dt_valid = 1'b0;
        if (t_valid === 1'b1) seen++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (t_valid === 1'b1) seen++;
        end
        checks++;
        if (T_out !== 8'd40 || seen != 0) begin
            failures++;
            $display("FAIL init_same_cycle: T_out=%0d t_valid pulses=%0d, want 40/0", $signed(T_out), seen);
        end
    endtask

    task automatic test_init_after();
        int seen;
        seen = 0;
        seed(10);
        dT_in = 8'd64; k_dt = 8'd1; dt_valid = 1'b1;
        @(negedge clk);
        dt_valid = 1'b0;
        init = 1'b1; T_seed = 8'd33;
        @(negedge clk);
        init = 1'b0;
        if (t_valid === 1'b1) seen++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (t_valid === 1'b1) seen++;
        end
        checks++;
        if (T_out !== 8'd33 || seen != 0) begin
            failures++;
            $display("FAIL init_after: T_out=%0d t_valid pulses=%0d, want 33/0", $signed(T_out), seen);
        end
    endtask

    task automatic test_rst_mid();
        int seen;
        seen = 0;
        seed(10);
        dT_in = 8'd64; k_dt = 8'd1; dt_valid = 1'b1;
        @(negedge clk);
        dt_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (T_out !== 8'd0 || t_valid !== 1'b0 || sat_hi !== 1'b0 || sat_lo !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: T_out=%0d t_valid=%b sat=%b%b running=%b, want all 0",
                     $signed(T_out), t_valid, sat_hi, sat_lo, running);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (t_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || T_out !== 8'd0 || running !== 1'b0) begin
            failures++;
            $display("FAIL rst_flush: t_valid pulses=%0d T_out=%0d running=%b, want 0/0/0", seen, $signed(T_out), running);
        end
    endtask

    task automatic test_cfg_err();
        int seen;
        seen = 0;
        seed(5);
        t_min = 8'd30;
        t_max = 8'd20;
        #1;
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL cfg_err_flag: cfg_err=%b, want 1", cfg_err);
        end
        dT_in = 8'd100; k_dt = 8'd7; dt_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (t_valid === 1'b1) seen++;
        end
        dt_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (t_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || T_out !== 8'd5) begin
            failures++;
            $display("FAIL cfg_err_block: t_valid pulses=%0d T_out=%0d, want 0/5", seen, $signed(T_out));
        end
        seed(50);
        checks++;
        if (T_out !== 8'd50) begin
            failures++;
            $display("FAIL cfg_err_seed: T_out=%0d, want 50 (unclamped)", $signed(T_out));
        end
        t_min = 8'h80;
        t_max = 8'h7f;
        #1;
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_clear: cfg_err=%b, want 0", cfg_err);
        end
    endtask

    // Reference: integer temperature*128, with a one-deep "pending" increment
    // representing a sample accepted but not yet added.
    task automatic test_random();
        int acc_m, pend, lo, hi, d, k, ke, s, v;
        bit pend_vld, exp_tv, exp_hi, exp_lo;
        int bad;
        bad = 0;
        lo = -128; hi = 127;
        t_min = 8'(lo); t_max = 8'(hi);
        seed(0);
        acc_m = 0; pend_vld = 0; pend = 0; exp_hi = 0; exp_lo = 0; exp_tv = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                lo = int'($urandom_range(0, 128)) - 128;
                hi = int'($urandom_range(0, 127));
            end
            d  = int'($urandom_range(0, 255)) - 128;
            k  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 255)) : int'($urandom_range(0, 7));
            ke = (k > 7) ? 7 : k;
            s  = int'($urandom_range(0, 255)) - 128;
            t_min = 8'(lo); t_max = 8'(hi);
            dT_in = 8'(d); k_dt = 8'(k); T_seed = 8'(s);
            dt_valid = ($urandom_range(0, 3) != 0);
            init     = ($urandom_range(0, 19) == 0);
            if (init) begin
                v = s * 128;
                if (v > hi * 128) v = hi * 128;
                if (v < lo * 128) v = lo * 128;
                acc_m = v; exp_tv = 0; exp_hi = 0; exp_lo = 0;
            end else if (pend_vld) begin
                v = acc_m + pend;
                exp_hi = 0; exp_lo = 0;
                if (v > hi * 128) begin v = hi * 128; exp_hi = 1; end
                else if (v < lo * 128) begin v = lo * 128; exp_lo = 1; end
                acc_m = v; exp_tv = 1;
            end else begin
                exp_tv = 0;
            end
            pend_vld = dt_valid && !init;
            pend     = d * (1 << ke);
            @(negedge clk);
            init = 1'b0;
            checks++;
            if (T_out !== 8'(acc_m >>> 7) || t_valid !== exp_tv || sat_hi !== exp_hi || sat_lo !== exp_lo) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d]: T_out=%0d tv=%b hi=%b lo=%b, want %0d/%b/%b/%b",
                             i, $signed(T_out), t_valid, sat_hi, sat_lo, acc_m >>> 7, exp_tv, exp_hi, exp_lo);
            end
        end
        dt_valid = 1'b0;
        t_min = 8'h80; t_max = 8'h7f;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        init     = 1'b0;
        T_seed   = 8'd0;
        dT_in    = 8'd0;
        dt_valid = 1'b0;
        k_dt     = 8'd0;
        t_min    = 8'h80;
        t_max    = 8'h7f;
        test_reset();
        test_idle_ignore();
        test_single();
        test_back_to_back();
        test_negative();
        test_saturation();
        test_init_same_cycle();
        test_init_after();
        test_rst_mid();
        test_cfg_err();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
